// File: rtl/npu_pool_pkg.sv
// Shared definitions for the pooling / unpooling datapath blocks.
package npu_pool_pkg;

    localparam int POOL_WIN = 4;

    typedef logic [1:0] pool_idx_t;

    typedef enum logic {UNPOOL_IDLE, UNPOOL_EMIT} unpool_state_t;

    localparam pool_idx_t POOL_LAST_POS = pool_idx_t'(POOL_WIN - 1);

endpackage

// File: rtl/max_unpool_4.sv
// Max-unpool: expands one (value, argmax) token into a serial 4-beat window.
// Define MAX_UNPOOL_FILL_EN to replicate the value on every beat instead of zero-filling.
module max_unpool_4
    import npu_pool_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_value,
    input  pool_idx_t        i_index,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output pool_idx_t        o_pos,
    output logic             o_last
);

    unpool_state_t    state_reg;
    pool_idx_t        cnt_reg;
    pool_idx_t        idx_reg;
    logic [WIDTH-1:0] value_reg;
    logic             emit;
    logic             at_last;
    logic             hit;

    assign emit    = (state_reg == UNPOOL_EMIT);
    assign at_last = emit && (cnt_reg == POOL_LAST_POS);

    // Ready on the final handshaking beat lets the next window start with no bubble.
    assign o_ready = !emit || (at_last && i_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= UNPOOL_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            value_reg <= '0;
        end else begin
            case (state_reg)
                UNPOOL_IDLE: begin
                    if (i_valid) begin
                        state_reg <= UNPOOL_EMIT;
                        value_reg <= i_value;
                        idx_reg   <= i_index;
                        cnt_reg   <= '0;
                    end
                end
                UNPOOL_EMIT: begin
                    if (i_ready) begin
                        if (cnt_reg == POOL_LAST_POS) begin
                            cnt_reg <= '0;
                            if (i_valid) begin
                                value_reg <= i_value;
                                idx_reg   <= i_index;
                            end else begin
                                state_reg <= UNPOOL_IDLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + pool_idx_t'(1);
                        end
                    end
                end
                default: state_reg <= UNPOOL_IDLE;
            endcase
        end
    end

`ifdef MAX_UNPOOL_FILL_EN
    assign hit = 1'b1;
`else
    assign hit = (cnt_reg == idx_reg);
`endif

    assign o_valid = emit;
    assign o_pos   = cnt_reg;
    assign o_last  = at_last;
    assign o_data  = (emit && hit) ? value_reg : '0;

endmodule

// File: tb/tb_max_unpool_4.sv
// Scoreboard bench for max_unpool_4: directed scenarios followed by randomized traffic.
module tb_max_unpool_4;
    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [WIDTH-1:0] i_value = '0;
    logic [1:0]       i_index = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_pos;
    logic             o_last;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]       pos;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t exp_q[$];

    logic             prev_stall = 1'b0;
    logic [1:0]       prev_pos;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    max_unpool_4 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_value (i_value),
        .i_index (i_index),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_pos   (o_pos),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a window is four beats; the argmax slot (or every slot in fill mode) carries value.
    function automatic logic [WIDTH-1:0] model_data(input int p, input int idx, input logic [WIDTH-1:0] v);
`ifdef MAX_UNPOOL_FILL_EN
        return v;
`else
        return (p == idx) ? v : '0;
`endif
    endfunction

    // Stimulus side: every accepted token queues its expected window.
    always @(posedge clk) begin
        if (rst_n && i_valid && o_ready) begin
            for (int p = 0; p < 4; p++) begin
                beat_t b;
                b.pos  = 2'(p);
                b.data = model_data(p, int'(i_index), i_value);
                b.last = (p == 3);
                exp_q.push_back(b);
            end
            $display("token accepted value=%02h index=%0d t=%0t", i_value, i_index, $time);
        end
    end

    // Monitor: handshake expectations from the pending-beat count, then beat compare and stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("o_valid", int'(o_valid), int'(exp_q.size() != 0));
            check("o_ready", int'(o_ready), int'(exp_q.size() == 0 || (exp_q.size() == 1 && i_ready)));
            if (prev_stall) begin
                check("hold_pos", int'(o_pos), int'(prev_pos));
                check("hold_data", int'(o_data), int'(prev_data));
                check("hold_last", int'(o_last), int'(prev_last));
            end
            if (o_valid && exp_q.size() != 0) begin
                check("o_pos", int'(o_pos), int'(exp_q[0].pos));
                check("o_data", int'(o_data), int'(exp_q[0].data));
                check("o_last", int'(o_last), int'(exp_q[0].last));
                if (i_ready) begin
                    $display("beat pos=%0d data=%02h last=%0b t=%0t", o_pos, o_data, o_last, $time);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_pos   = o_pos;
            prev_data  = o_data;
            prev_last  = o_last;
        end
    end

    task automatic send(input logic [WIDTH-1:0] v, input logic [1:0] idx);
        int waited = 0;
        i_valid = 1'b1;
        i_value = v;
        i_index = idx;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            waited++;
            if (waited > 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    bit rand_done;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", int'(o_valid), 0);
        check("reset_o_pos", int'(o_pos), 0);
        check("reset_o_last", int'(o_last), 0);
        check("reset_o_data", int'(o_data), 0);
        rst_n = 1'b1;
        i_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single window, then back-to-back windows (second token held off until the last beat).
        send(6'h2A, 2'd2);
        drain();
        send(6'h05, 2'd0);
        send(6'h3F, 2'd3);
        drain();

        // Backpressure at pos 1 for three cycles.
        send(6'h11, 2'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_valid", int'(o_valid), 1);
            check("stall_pos", int'(o_pos), 1);
            check("stall_data", int'(o_data), int'(model_data(1, 1, 6'h11)));
        end
        i_ready = 1'b1;
        drain();

        // Asynchronous reset at pos 2 drops the partial window.
        send(6'h33, 2'd2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_pos", int'(o_pos), 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(o_valid), 0);
        check("async_rst_pos", int'(o_pos), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(6'h07, 2'd0);
        check("post_reset_pos", int'(o_pos), 0);
        check("post_reset_data", int'(o_data), 6'h07);
        drain();

        // Randomized traffic with random downstream stalls.
        rand_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    send(WIDTH'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
